// File: rtl/vga_char_bouncer.sv
// Moves a CHAR_W x CHAR_H box one step per video frame and bounces it off the active-area edges.
// Latency: frame_tick 3 cycles after the first low vsync sample; position/colour update 1 cycle after frame_tick.
// No backpressure: free-running; run_en=0 freezes position and colour while frame_tick keeps pulsing.
module vga_char_bouncer #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int CHAR_W     = 64,
    parameter int CHAR_H     = 16,
    parameter int STEP_X     = 2,
    parameter int STEP_Y     = 1,
    parameter int X_INIT     = 0,
    parameter int Y_INIT     = 0,
    parameter int COLOR_INIT = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       vsync,
    input  logic       run_en,
    output logic [9:0] char_x_start,
    output logic [9:0] char_x_end,
    output logic [9:0] char_y_start,
    output logic [9:0] char_y_end,
    output logic [3:0] char_color,
    output logic       frame_tick,
    output logic       corner_hit
);

    localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - CHAR_W);
    localparam logic [10:0] Y_MAX   = 11'(V_ACTIVE - CHAR_H);
    localparam logic [9:0]  X_MAX10 = 10'(H_ACTIVE - CHAR_W);
    localparam logic [9:0]  Y_MAX10 = 10'(V_ACTIVE - CHAR_H);
    localparam logic [10:0] SX      = 11'(STEP_X);
    localparam logic [10:0] SY      = 11'(STEP_Y);
    localparam logic [9:0]  W_M1    = 10'(CHAR_W - 1);
    localparam logic [9:0]  H_M1    = 10'(CHAR_H - 1);

    logic       vs_s1_q, vs_s2_q, vs_d_q;
    logic [1:0] smp_q;
    logic       armed_q;
    logic       tick_q;

    logic [9:0] x_q, y_q, x_end_q, y_end_q;
    logic [9:0] x_d, y_d, x_end_d, y_end_d;
    logic       dir_x_q, dir_y_q, dir_x_d, dir_y_d;
    logic [3:0] color_q, color_d;
    logic       corner_q;
    logic       bx, by, upd;
    logic [10:0] x_ext, y_ext, x_sum, y_sum, x_dif, y_dif;

    // vsync synchronizer and falling-edge detector. The reset value of the
    // synchronizer is not a real sample, so the detector only arms once a
    // genuinely sampled high vsync has been seen: a vsync already low at
    // reset release cannot produce a spurious tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vs_s1_q <= 1'b1;
            vs_s2_q <= 1'b1;
            vs_d_q  <= 1'b1;
            smp_q   <= 2'b00;
            armed_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            vs_s1_q <= vsync;
            vs_s2_q <= vs_s1_q;
            vs_d_q  <= vs_s2_q;
            smp_q   <= {smp_q[0], 1'b1};
            if (smp_q[1] && vs_s2_q) begin
                armed_q <= 1'b1;
            end
            tick_q  <= armed_q & vs_d_q & ~vs_s2_q;
        end
    end

    // Next position, direction and colour; 11-bit math keeps the edge tests free of wrap-around.
    always_comb begin
        x_ext   = {1'b0, x_q};
        y_ext   = {1'b0, y_q};
        x_sum   = x_ext + SX;
        y_sum   = y_ext + SY;
        x_dif   = x_ext - SX;
        y_dif   = y_ext - SY;
        x_d     = x_q;
        y_d     = y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        bx      = 1'b0;
        by      = 1'b0;
        if (!dir_x_q) begin
            if (x_sum >= X_MAX) begin
                x_d = X_MAX10; dir_x_d = 1'b1; bx = 1'b1;
            end else begin
                x_d = 10'(x_sum);
            end
        end else begin
            if (x_ext <= SX) begin
                x_d = '0; dir_x_d = 1'b0; bx = 1'b1;
            end else begin
                x_d = 10'(x_dif);
            end
        end
        if (!dir_y_q) begin
            if (y_sum >= Y_MAX) begin
                y_d = Y_MAX10; dir_y_d = 1'b1; by = 1'b1;
            end else begin
                y_d = 10'(y_sum);
            end
        end else begin
            if (y_ext <= SY) begin
                y_d = '0; dir_y_d = 1'b0; by = 1'b1;
            end else begin
                y_d = 10'(y_dif);
            end
        end
        color_d = color_q + {3'b000, (bx | by)};
        x_end_d = x_d + W_M1;
        y_end_d = y_d + H_M1;
        upd     = tick_q & run_en;
    end

    // Box state and output registers, advanced only on an enabled frame tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            x_q      <= 10'(X_INIT);
            y_q      <= 10'(Y_INIT);
            x_end_q  <= 10'(X_INIT + CHAR_W - 1);
            y_end_q  <= 10'(Y_INIT + CHAR_H - 1);
            dir_x_q  <= 1'b0;
            dir_y_q  <= 1'b0;
            color_q  <= 4'(COLOR_INIT);
            corner_q <= 1'b0;
        end else if (upd) begin
            x_q      <= x_d;
            y_q      <= y_d;
            x_end_q  <= x_end_d;
            y_end_q  <= y_end_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            color_q  <= color_d;
            corner_q <= bx & by;
        end else begin
            corner_q <= 1'b0;
        end
    end

    assign char_x_start = x_q;
    assign char_x_end   = x_end_q;
    assign char_y_start = y_q;
    assign char_y_end   = y_end_q;
    assign char_color   = color_q;
    assign frame_tick   = tick_q;
    assign corner_hit   = corner_q;

endmodule

// File: tb/tb_vga_char_bouncer.sv
// Randomized frame-level bench: three boxes with different start points share vsync/run_en.
// A per-frame reference model predicts box position, colour and corner pulses.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_vga_char_bouncer;

    localparam int NI = 3;
    localparam int XI[NI] = '{0, 574, 575};
    localparam int YI[NI] = '{0, 463, 0};
    localparam int CI[NI] = '{1, 15, 1};
    localparam int XMX = 576;
    localparam int YMX = 464;
    localparam int SXT = 2;
    localparam int SYT = 1;
    localparam int CW  = 64;
    localparam int CH  = 16;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic vsync     = 1'b1;
    logic run_en    = 1'b0;

    logic [9:0] xs[NI];
    logic [9:0] xe[NI];
    logic [9:0] ys[NI];
    logic [9:0] ye[NI];
    logic [3:0] col[NI];
    logic       ft[NI];
    logic       ch[NI];

    always #10 sys_clk = ~sys_clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        vga_char_bouncer #(
            .X_INIT(XI[g]),
            .Y_INIT(YI[g]),
            .COLOR_INIT(CI[g])
        ) u_dut (
            .sys_clk     (sys_clk),
            .sys_rst_n   (sys_rst_n),
            .vsync       (vsync),
            .run_en      (run_en),
            .char_x_start(xs[g]),
            .char_x_end  (xe[g]),
            .char_y_start(ys[g]),
            .char_y_end  (ye[g]),
            .char_color  (col[g]),
            .frame_tick  (ft[g]),
            .corner_hit  (ch[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int mx[NI], my[NI], mdx[NI], mdy[NI], mc[NI], mcorner[NI];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            mx[k] = XI[k]; my[k] = YI[k];
            mdx[k] = 0; mdy[k] = 0;
            mc[k] = CI[k]; mcorner[k] = 0;
        end
    endtask

    // one axis of motion: move by s toward the current direction, clamp and reverse at an edge
    task automatic axis(input int p_in, input int d_in, input int lim, input int s,
                        output int p, output int d, output int b);
        p = p_in; d = d_in; b = 0;
        if (d == 0) begin
            if (p + s >= lim) begin p = lim; d = 1; b = 1; end
            else p = p + s;
        end else begin
            if (p <= s) begin p = 0; d = 0; b = 1; end
            else p = p - s;
        end
    endtask

    task automatic model_frame(input bit en);
        int bx, by, p, d;
        for (int k = 0; k < NI; k++) begin
            mcorner[k] = 0;
            if (en) begin
                axis(mx[k], mdx[k], XMX, SXT, p, d, bx); mx[k] = p; mdx[k] = d;
                axis(my[k], mdy[k], YMX, SYT, p, d, by); my[k] = p; mdy[k] = d;
                if (bx != 0 || by != 0) mc[k] = (mc[k] + 1) % 16;
                mcorner[k] = (bx != 0 && by != 0) ? 1 : 0;
            end
        end
    endtask

    task automatic check_outputs(input string pfx);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s x_start[%0d]", pfx, k), int'(xs[k]), mx[k]);
            chk($sformatf("%s x_end[%0d]", pfx, k), int'(xe[k]), mx[k] + CW - 1);
            chk($sformatf("%s y_start[%0d]", pfx, k), int'(ys[k]), my[k]);
            chk($sformatf("%s y_end[%0d]", pfx, k), int'(ye[k]), my[k] + CH - 1);
            chk($sformatf("%s color[%0d]", pfx, k), int'(col[k]), mc[k]);
        end
    endtask

    // one frame: vsync low for 'low' cycles then high for 'high' cycles (low>=3, high>=5)
    task automatic do_frame(input string pfx, input int low, input int high, input bit en);
        int nt[NI], nc[NI];
        int tat;
        tat = -1;
        for (int k = 0; k < NI; k++) begin nt[k] = 0; nc[k] = 0; end
        run_en = en;
        vsync  = 1'b0;
        for (int i = 1; i <= low + high; i++) begin
            @(negedge sys_clk);
            for (int k = 0; k < NI; k++) begin
                if (ft[k]) nt[k]++;
                if (ch[k]) nc[k]++;
            end
            if (ft[0] && tat < 0) tat = i;
            if (i == low) vsync = 1'b1;
        end
        model_frame(en);
        chk({pfx, " tick_cycle"}, tat, 3);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s ticks[%0d]", pfx, k), nt[k], 1);
            chk($sformatf("%s corner[%0d]", pfx, k), nc[k], mcorner[k]);
        end
        check_outputs(pfx);
    endtask

    task automatic count_quiet(input int cycles, output int nt, output int nc);
        nt = 0; nc = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge sys_clk);
            for (int k = 0; k < NI; k++) begin
                if (ft[k]) nt++;
                if (ch[k]) nc++;
            end
        end
    endtask

    initial begin
        int nt, nc, seen;

        // reset state
        model_reset();
        repeat (3) @(negedge sys_clk);
        chk("rst x_start", int'(xs[0]), 0);
        chk("rst x_end", int'(xe[0]), 63);
        chk("rst y_start", int'(ys[0]), 0);
        chk("rst y_end", int'(ye[0]), 15);
        chk("rst color", int'(col[0]), 1);
        chk("rst frame_tick", int'(ft[0]), 0);
        chk("rst corner_hit", int'(ch[0]), 0);
        check_outputs("rst");

        // release with vsync high: no tick
        sys_rst_n = 1'b1;
        count_quiet(10, nt, nc);
        chk("release ticks", nt, 0);

        // single step, right-edge clamp, corner and colour wrap on the first frame
        do_frame("f1", 4, 20, 1'b1);
        chk("step x_start", int'(xs[0]), 2);
        chk("step x_end", int'(xe[0]), 65);
        chk("step y_start", int'(ys[0]), 1);
        chk("step y_end", int'(ye[0]), 16);
        chk("step color", int'(col[0]), 1);
        chk("clamp x_start", int'(xs[2]), 576);
        chk("clamp x_end", int'(xe[2]), 639);
        chk("clamp color", int'(col[2]), 2);
        chk("corner x_start", int'(xs[1]), 576);
        chk("corner y_start", int'(ys[1]), 464);
        chk("wrap color", int'(col[1]), 0);

        do_frame("f2", 3, 10, 1'b1);
        chk("back x_start", int'(xs[2]), 574);
        chk("corner back x", int'(xs[1]), 574);
        chk("corner back y", int'(ys[1]), 463);

        // freeze over 5 frames
        for (int f = 0; f < 5; f++) do_frame("freeze", 3 + f % 2, 8, 1'b0);

        // randomized frames
        for (int f = 0; f < 500; f++) begin
            do_frame("rnd", $urandom_range(3, 6), $urandom_range(5, 25),
                     ($urandom_range(0, 9) != 0));
        end

        // vsync already low at release: no tick
        vsync = 1'b0;
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        count_quiet(10, nt, nc);
        vsync = 1'b1;
        begin
            int nt2, nc2;
            count_quiet(10, nt2, nc2);
            nt = nt + nt2;
        end
        chk("low-release ticks", nt, 0);
        model_reset();
        check_outputs("low-release");
        do_frame("post-low", 4, 12, 1'b1);

        // reset while frame_tick is high
        run_en = 1'b1;
        vsync  = 1'b0;
        seen   = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge sys_clk);
            if (ft[0]) seen = 1;
        end
        chk("midrst tick seen", seen, 1);
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst frame_tick", int'(ft[0]), 0);
        check_outputs("midrst asserted");
        @(negedge sys_clk);
        vsync = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        count_quiet(10, nt, nc);
        chk("midrst ticks", nt, 0);
        chk("midrst corners", nc, 0);
        check_outputs("midrst released");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
